// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - Tile command sequencer feeding SA_CORE and draining its result vectors
// Optional SA_SEQ_SKEW_EN: per-row input skew plus ROWS-1 diagonal flush cycles at the end of FEED.
module sa_seq_ctrl #(
    parameter int ROWS    = 8,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [$clog2(ROWS):0] cmd_nres,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*8-1:0]     in_a,
    input  logic [ROWS*8-1:0]     in_w,
    output logic [ROWS*8-1:0]     core_a,
    output logic [ROWS*8-1:0]     core_w,
    output logic                  core_inpvalid,
    output logic                  core_outread,
    input  logic [ROWS*32-1:0]    core_res,
    input  logic [ROWS-1:0]       core_rvalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROWS*32-1:0]    out_data,
    output logic                  out_last,
    output logic                  done,
    output logic [1:0]            err,
    output logic                  busy
);
    localparam int NRES_W = $clog2(ROWS) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_OUT, S_FIN} state_t;
    state_t state, state_nxt;

    logic [LEN_W-1:0]  len_q, feed_cnt;
    logic [NRES_W-1:0] nres_q, res_cnt, nres_clamp;
    logic [WAIT_W-1:0] wait_cnt;
    logic cmd_fire, in_fire, out_fire, feed_open, feed_last, feed_done, feed_strobe;
    logic all_valid, timeout_hit, res_last;

    assign all_valid   = &core_rvalid;
    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign res_last    = (res_cnt == nres_q - NRES_W'(1));
    assign feed_last   = (feed_cnt == len_q - LEN_W'(1));
    assign cmd_fire    = cmd_valid && (state == S_IDLE);
    assign in_fire     = in_valid && feed_open;
    assign out_fire    = out_ready && (state == S_OUT);

    assign cmd_ready    = (state == S_IDLE);
    assign in_ready     = feed_open;
    assign out_valid    = (state == S_OUT);
    assign core_outread = out_fire;
    assign out_last     = out_fire && res_last;
    assign busy         = (state != S_IDLE);

    // A zero result count still drains one vector; anything above ROWS is capped.
    always_comb begin
        nres_clamp = cmd_nres;
        if (cmd_nres == '0)
            nres_clamp = NRES_W'(1);
        else if (cmd_nres > NRES_W'(ROWS))
            nres_clamp = NRES_W'(ROWS);
    end

`ifdef SA_SEQ_SKEW_EN
    logic              flushing;
    logic [NRES_W-1:0] flush_cnt;
    logic [7:0]        a_pipe [ROWS][ROWS];
    logic [7:0]        w_pipe [ROWS][ROWS];

    assign feed_open   = (state == S_FEED) && !flushing;
    assign feed_strobe = in_fire || flushing;
    assign feed_done   = (ROWS > 1) ? (flushing && flush_cnt == NRES_W'(ROWS - 2))
                                    : (in_fire && feed_last);

    // Stage d of row r; row r is presented from stage r, so bubbles and flush shift in zeros.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flushing  <= 1'b0;
            flush_cnt <= '0;
            for (int d = 0; d < ROWS; d++) begin
                for (int r = 0; r < ROWS; r++) begin
                    a_pipe[d][r] <= 8'd0;
                    w_pipe[d][r] <= 8'd0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_pipe[0][r] <= in_fire ? in_a[8*r +: 8] : 8'd0;
                w_pipe[0][r] <= in_fire ? in_w[8*r +: 8] : 8'd0;
                for (int d = 1; d < ROWS; d++) begin
                    a_pipe[d][r] <= a_pipe[d-1][r];
                    w_pipe[d][r] <= w_pipe[d-1][r];
                end
            end
            if (in_fire && feed_last && (ROWS > 1)) begin
                flushing  <= 1'b1;
                flush_cnt <= '0;
            end else if (flushing) begin
                flush_cnt <= flush_cnt + NRES_W'(1);
                if (feed_done)
                    flushing <= 1'b0;
            end
        end
    end

    always_comb begin
        core_a = '0;
        core_w = '0;
        for (int r = 0; r < ROWS; r++) begin
            core_a[8*r +: 8] = a_pipe[r][r];
            core_w[8*r +: 8] = w_pipe[r][r];
        end
    end
`else
    assign feed_open   = (state == S_FEED);
    assign feed_strobe = in_fire;
    assign feed_done   = in_fire && feed_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_a <= '0;
            core_w <= '0;
        end else if (in_fire) begin
            core_a <= in_a;
            core_w <= in_w;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_nxt = (cmd_len == '0) ? S_FIN : S_FEED;
            S_FEED:  if (feed_done) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (all_valid)
                    state_nxt = S_OUT;
                else if (timeout_hit)
                    state_nxt = S_FIN;
            end
            S_OUT:   if (out_fire) state_nxt = res_last ? S_FIN : S_DRAIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            len_q         <= '0;
            nres_q        <= '0;
            feed_cnt      <= '0;
            res_cnt       <= '0;
            wait_cnt      <= '0;
            out_data      <= '0;
            err           <= 2'b00;
            done          <= 1'b0;
            core_inpvalid <= 1'b0;
        end else begin
            state         <= state_nxt;
            done          <= (state_nxt == S_FIN);
            core_inpvalid <= feed_strobe;
            if (cmd_fire) begin
                len_q    <= cmd_len;
                nres_q   <= nres_clamp;
                feed_cnt <= '0;
                res_cnt  <= '0;
                err      <= {1'b0, cmd_len == '0};
            end
            if (in_fire)
                feed_cnt <= feed_cnt + LEN_W'(1);
            // Held at zero outside DRAIN so every DRAIN visit gets the full wait budget.
            wait_cnt <= (state == S_DRAIN) ? wait_cnt + WAIT_W'(1) : '0;
            if (state == S_DRAIN && all_valid)
                out_data <= core_res;
            if (state == S_DRAIN && !all_valid && timeout_hit)
                err[1] <= 1'b1;
            if (out_fire)
                res_cnt <= res_cnt + NRES_W'(1);
        end
    end
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb/tb_sa_seq_ctrl.sv - Directed and randomized checks of sa_seq_ctrl against a behavioural core model
module tb_sa_seq_ctrl;
    localparam int ROWS    = 4;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 16;
    localparam int NRES_W  = $clog2(ROWS) + 1;
    localparam int DW      = ROWS * 32;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len = '0;
    logic [NRES_W-1:0]   cmd_nres = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ROWS*8-1:0]   in_a = '0;
    logic [ROWS*8-1:0]   in_w = '0;
    logic [ROWS*8-1:0]   core_a, core_w;
    logic                core_inpvalid, core_outread;
    logic [ROWS*32-1:0]  core_res = '0;
    logic [ROWS-1:0]     core_rvalid = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [ROWS*32-1:0]  out_data;
    logic                out_last, done, busy;
    logic [1:0]          err;

    int n_assert = 0;
    int n_fail = 0;

    sa_seq_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_nres(cmd_nres),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .core_a(core_a), .core_w(core_w), .core_inpvalid(core_inpvalid), .core_outread(core_outread),
        .core_res(core_res), .core_rvalid(core_rvalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for SA_CORE: results become valid 3 cycles after the last input and 1..3 cycles after each read.
    logic [DW-1:0] ld_q[$];
    int            ld_len = 0;
    int            ld_seq = 0;
    logic [DW-1:0] cm_q[$];
    int            cm_len = 0, cm_seen = 0, cm_wait = -1, cm_seq = 0;

    function automatic logic [DW-1:0] rand_res();
        logic [DW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[32*r +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ROWS*8-1:0] rand_vec();
        logic [ROWS*8-1:0] v;
        for (int r = 0; r < ROWS; r++) v[8*r +: 8] = 8'($urandom);
        return v;
    endfunction

    always @(negedge clk) begin
        logic [ROWS-1:0] part;
        if (ld_seq != cm_seq) begin
            cm_q = ld_q;
            cm_len = ld_len;
            cm_seen = 0;
            cm_wait = -1;
            cm_seq = ld_seq;
        end else if (core_outread && cm_q.size() > 0) begin
            cm_q.delete(0);
            cm_wait = 1 + int'($urandom_range(0, 2));
        end else if (core_inpvalid) begin
            cm_seen++;
            if (cm_seen == cm_len) cm_wait = 3;
        end else if (cm_wait > 0) begin
            cm_wait--;
        end
        if (cm_q.size() > 0 && cm_wait == 0) begin
            core_rvalid = '1;
            core_res = cm_q[0];
        end else begin
            part = ROWS'($urandom);
            part[$urandom_range(0, ROWS-1)] = 1'b0;
            core_rvalid = part;
            core_res = rand_res();
        end
    end

    // Passive monitor: records feed vectors, result beats and per-cycle protocol violations.
    logic [ROWS*8-1:0] mon_a[$], mon_w[$];
    bit                mon_ipv[$];
    logic [DW-1:0]     mon_beat[$];
    bit                mon_last[$];
    int mon_inp = 0, mon_rd = 0, mon_done = 0;
    int bad_hold = 0, bad_stall = 0, bad_rd = 0, bad_last = 0, bad_cr = 0;
    logic [ROWS*8-1:0] last_a = '0, last_w = '0;
    logic              prev_ov = 1'b0, prev_fire = 1'b0;
    logic [DW-1:0]     prev_od = '0;

    always @(negedge clk) begin
        mon_ipv.push_back(core_inpvalid);
        if (!rstn) begin
            last_a = '0;
            last_w = '0;
        end else if (core_inpvalid) begin
            mon_inp++;
            mon_a.push_back(core_a);
            mon_w.push_back(core_w);
            last_a = core_a;
            last_w = core_w;
        end else if (busy && (core_a !== last_a || core_w !== last_w)) begin
            bad_hold++;
        end
        if (out_valid && prev_ov && !prev_fire && out_data !== prev_od) bad_stall++;
        if (core_outread !== (out_valid && out_ready)) bad_rd++;
        if (out_last && !(out_valid && out_ready)) bad_last++;
        if (cmd_ready !== !busy) bad_cr++;
        if (core_outread) mon_rd++;
        if (out_valid && out_ready) begin
            mon_beat.push_back(out_data);
            mon_last.push_back(out_last);
        end
        if (done) mon_done++;
        prev_ov = out_valid;
        prev_fire = out_valid && out_ready;
        prev_od = out_data;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input int len, input int nres, input bit bubbles,
                           input int stall, input bit no_res, input int abort_at);
        int nres_eff, exp_beats, exp_done;
        int b_inp, b_ipv, b_beat, b_rd, b_done, b_hold, b_stall, b_rdb, b_last, b_cr;
        int sent, pidx, hold, hs_cyc, done_cyc, first1, last1, mism;
        logic [1:0] exp_err;
        logic [ROWS*8-1:0] va[$], vw[$];
        logic [ROWS*8-1:0] ta, tw;
        logic [DW-1:0] er[$];
        logic [DW-1:0] acc;
        logic [31:0] s;
        bit plan[$];

        nres_eff = (nres == 0) ? 1 : ((nres > ROWS) ? ROWS : nres);
        for (int i = 0; i < len; i++) begin
            va.push_back(rand_vec());
            vw.push_back(rand_vec());
            plan.push_back(1'b1);
            if (bubbles && i < len - 1) plan.push_back(1'b0);
        end
        for (int k = 0; k < nres_eff; k++) begin
            for (int r = 0; r < ROWS; r++) begin
                s = 32'(k * 1000 + r);
                for (int j = 0; j < len; j++) begin
                    ta = va[j];
                    tw = vw[j];
                    s = s + 32'(ta[8*r +: 8]) * 32'(tw[8*r +: 8]);
                end
                acc[32*r +: 32] = s;
            end
            er.push_back(acc);
        end
        exp_err   = (len == 0) ? 2'b01 : (no_res ? 2'b10 : 2'b00);
        exp_beats = (len == 0 || no_res) ? 0 : nres_eff;

        if (no_res) ld_q.delete();
        else ld_q = er;
        ld_len = len;
        ld_seq++;

        b_inp = mon_inp; b_ipv = mon_ipv.size(); b_beat = mon_beat.size(); b_rd = mon_rd;
        b_done = mon_done; b_hold = bad_hold; b_stall = bad_stall; b_rdb = bad_rd;
        b_last = bad_last; b_cr = bad_cr;

        cmd_valid = 1'b1;
        cmd_len = LEN_W'(len);
        cmd_nres = NRES_W'(nres);
        @(negedge clk);
        chk({tag, " cmd_ready"}, DW'(cmd_ready), DW'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, " err_at_accept"}, DW'(err), DW'({1'b0, len == 0}));

        sent = 0; pidx = 0; hold = 0; hs_cyc = -1; done_cyc = -1;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            in_valid = (pidx < plan.size()) ? plan[pidx] : 1'b0;
            in_a = (in_valid && sent < len) ? va[sent] : rand_vec();
            in_w = (in_valid && sent < len) ? vw[sent] : rand_vec();
            out_ready = (stall == 0) ? 1'b1 : (out_valid && hold >= stall);
            @(negedge clk);
            if (pidx < plan.size() && in_ready) pidx++;
            if (in_valid && in_ready) begin
                sent++;
                hs_cyc = cyc;
            end
            if (out_valid) hold = out_ready ? 0 : hold + 1;
            if (done) done_cyc = cyc;
            if (abort_at >= 0 && sent == abort_at) begin
                in_valid = 1'b0;
                rstn = 1'b0;
                #1;
                chk({tag, " rst cmd_ready"}, DW'(cmd_ready), DW'(1));
                chk({tag, " rst busy/in_ready/out_valid"}, DW'({busy, in_ready, out_valid}), DW'(0));
                chk({tag, " rst inpvalid/outread/done"}, DW'({core_inpvalid, core_outread, done}), DW'(0));
                chk({tag, " rst core_a/core_w"}, DW'({core_a, core_w}), DW'(0));
                chk({tag, " rst out_data/last/err"}, DW'({out_data, out_last, err}), DW'(0));
                @(posedge clk); #1;
                rstn = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk({tag, " cmd_ready_after_done"}, DW'(cmd_ready), DW'(1));
        @(negedge clk);
        chk({tag, " done_single_pulse"}, DW'({done, 32'(mon_done - b_done)}), DW'({1'b0, 32'd1}));
        chk({tag, " err"}, DW'(err), DW'(exp_err));

        if (len == 0 || no_res) begin
            exp_done = (len == 0) ? 0 : hs_cyc + 1 + TIMEOUT;
            chk({tag, " done_cycle"}, DW'(done_cyc), DW'(exp_done));
        end else begin
            chk({tag, " done_seen"}, DW'(done_cyc >= 0), DW'(1));
        end

        chk({tag, " inpvalid_count"}, DW'(mon_inp - b_inp), DW'(len));
        for (int i = 0; i < len && b_inp + i < mon_a.size(); i++) begin
            chk($sformatf("%s feed_vec%0d", tag, i), DW'({mon_a[b_inp + i], mon_w[b_inp + i]}),
                DW'({va[i], vw[i]}));
        end
        if (len > 0) begin
            first1 = -1; last1 = -1; mism = 0;
            for (int i = b_ipv; i < mon_ipv.size(); i++) begin
                if (mon_ipv[i]) begin
                    if (first1 < 0) first1 = i;
                    last1 = i;
                end
            end
            chk({tag, " inpvalid_span"}, DW'(last1 - first1 + 1), DW'(plan.size()));
            for (int i = 0; i < plan.size() && first1 >= 0 && first1 + i < mon_ipv.size(); i++)
                if (mon_ipv[first1 + i] != plan[i]) mism++;
            chk({tag, " inpvalid_pattern"}, DW'(mism), DW'(0));
        end

        chk({tag, " beats"}, DW'(mon_beat.size() - b_beat), DW'(exp_beats));
        chk({tag, " outread_pulses"}, DW'(mon_rd - b_rd), DW'(exp_beats));
        for (int k = 0; k < exp_beats && b_beat + k < mon_beat.size(); k++) begin
            chk($sformatf("%s beat%0d", tag, k), mon_beat[b_beat + k], er[k]);
            chk($sformatf("%s last%0d", tag, k), DW'(mon_last[b_beat + k]), DW'(k == exp_beats - 1));
        end
        chk({tag, " core_a_hold"}, DW'(bad_hold - b_hold), DW'(0));
        chk({tag, " out_stall_stable"}, DW'(bad_stall - b_stall), DW'(0));
        chk({tag, " outread_eq_handshake"}, DW'(bad_rd - b_rdb), DW'(0));
        chk({tag, " last_only_on_beat"}, DW'(bad_last - b_last), DW'(0));
        chk({tag, " cmd_ready_eq_idle"}, DW'(bad_cr - b_cr), DW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_ready", DW'(cmd_ready), DW'(1));
        chk("reset busy/in_ready/out_valid", DW'({busy, in_ready, out_valid}), DW'(0));
        chk("reset inpvalid/done/err", DW'({core_inpvalid, done, err}), DW'(0));
        chk("reset core_a/core_w", DW'({core_a, core_w}), DW'(0));
        chk("reset out_data/out_last", DW'({out_data, out_last}), DW'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_cmd("basic",        4, 1, 1'b0, 0, 1'b0, -1);
        run_cmd("bubbles",      3, 1, 1'b1, 0, 1'b0, -1);
        run_cmd("backpressure", 5, 3, 1'b0, 5, 1'b0, -1);
        run_cmd("zero_len",     0, 2, 1'b0, 0, 1'b0, -1);
        run_cmd("after_zero",   2, 2, 1'b0, 1, 1'b0, -1);
        run_cmd("nres_clamp",   3, 7, 1'b0, 0, 1'b0, -1);
        run_cmd("nres_zero",    2, 0, 1'b1, 2, 1'b0, -1);
        run_cmd("timeout",      3, 2, 1'b0, 0, 1'b1, -1);
        run_cmd("after_to",     1, 1, 1'b0, 0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run_cmd($sformatf("rand%0d", i), int'($urandom_range(1, 6)), int'($urandom_range(0, 7)),
                    1'($urandom), int'($urandom_range(0, 3)), 1'b0, -1);
        end
        run_cmd("mid_feed_rst", 8, 1, 1'b0, 0, 1'b0, 2);
        run_cmd("after_rst",    8, 2, 1'b0, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_seq_ctrl.md
Name: sa_seq_ctrl

Overview:
- Sequencer sitting between the tile buffers and SA_CORE.
- Accepts one command per tile and streams cmd_len activation/weight vectors into the core with inpvalid.
- Drains cmd_nres result vectors via outread and reports completion or error.
- Only block allowed to drive SA_CORE inpvalid/outread.

Parameters:
- ROWS, 8, array rows/columns; width of core vector ports.
- LEN_W, 16, width of cmd_len and the feed counter.
- TIMEOUT, 1024, max DRAIN cycles waiting for a result before error.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  LEN_W  number of input vectors to feed
- cmd_nres  in  $clog2(ROWS)+1  result vectors to drain, 1..ROWS
- in_valid  in  1  input vector available
- in_ready  out  1  high only in FEED
- in_a  in  ROWS*8  activation vector, row i at [8i+7:8i]
- in_w  in  ROWS*8  weight vector, same packing
- core_a  out  ROWS*8  to SA_CORE ainport
- core_w  out  ROWS*8  to SA_CORE winport
- core_inpvalid  out  1  to SA_CORE inpvalid
- core_outread  out  1  to SA_CORE outread
- core_res  in  ROWS*32  from SA_CORE routport
- core_rvalid  in  ROWS  from SA_CORE rvalidport
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts
- out_data  out  ROWS*32  result vector
- out_last  out  1  marks the final result of a command
- done  out  1  one-cycle pulse at command end
- err  out  2  sticky status: bit0 len-zero, bit1 timeout; cleared on next cmd accept
- busy  out  1  state != IDLE

Behaviour:
- Reset: async on rstn low. State IDLE; counters 0. All outputs 0 except cmd_ready=1.
- Registered outputs: core_a, core_w, core_inpvalid, done, err.
- States: IDLE, FEED, DRAIN, OUT, FIN.
- IDLE:
  - On cmd_valid&&cmd_ready, latch len/nres and clear err.
  - len==0: set err[0], go FIN, no core activity.
  - Otherwise go FEED.
- FEED:
  - in_ready=1.
  - Each in handshake registers in_a/in_w to core_a/core_w with core_inpvalid=1 next cycle (latency 1).
  - Cycles without a handshake give core_inpvalid=0; core_a/core_w hold.
  - Feed counter increments per handshake. The handshake with counter==len-1 moves to DRAIN.
- DRAIN:
  - Wait for core_rvalid all-ones; then latch core_res into out_data and go OUT.
  - Partial rvalid is ignored.
  - Wait counter starts at 0 on each DRAIN entry. Reaching TIMEOUT-1 without all-ones sets err[1] and goes FIN; any remaining results are abandoned.
- OUT:
  - out_valid=1, held with stable out_data until out_ready.
  - On handshake: core_outread=1 for exactly that cycle (combinational from the handshake), and the result counter increments.
  - If the counter was nres-1: out_last=1 on that beat, go FIN. Otherwise return to DRAIN; the next result is recognised no earlier than 1 cycle after outread.
- FIN: done=1 for one cycle, go IDLE. cmd_ready returns the following cycle.
- nres > ROWS is clamped to ROWS; nres==0 is treated as 1.
- Counter wrap: the feed counter never wraps, since len <= 2^LEN_W-1 is compared before increment.
- Mid-command reset: returns to IDLE immediately; any partially fed tile is discarded.

Optional Feature:
- Macro: SA_SEQ_SKEW_EN.
- Defined:
  - Row i of core_a and core_w is delayed i cycles via per-row shift registers (row 0 = latency 1).
  - After the last feed handshake, FEED holds for ROWS-1 extra cycles with core_inpvalid=1 and zero-filled rows, flushing the diagonal, before entering DRAIN.
- Undefined: all rows are presented aligned; no extra cycles.

Test Plan:
- Basic: cmd_len=4, cmd_nres=1, in_a rows=1..4, always-ready I/O, model returns rvalid=all-ones 3 cycles after last inpvalid -> core_inpvalid high exactly 4 cycles; one out beat with out_last=1; done pulse; err=0.
- Input bubbles: in_valid toggles 1,0,1,0 for len=3 -> core_inpvalid pattern 1,0,1,0,1; core_a holds during 0 cycles.
- Backpressure: nres=3, out_ready low 5 cycles per beat -> out_data stable while stalled; core_outread exactly 3 single-cycle pulses; out_last only on third.
- Zero length: cmd_len=0 -> no core_inpvalid; done after 2 cycles; err=2'b01; next cmd clears err.
- Timeout: TIMEOUT=16, model never asserts rvalid -> err=2'b10 and done 16 cycles after DRAIN entry; cmd_ready=1 the next cycle.
- Reset mid-FEED: rstn low after 2 of 8 vectors -> all outputs 0 immediately, cmd_ready=1; a new command then completes normally (with SA_SEQ_SKEW_EN, core_inpvalid spans len+ROWS-1 cycles).
